// File: rtl/key_loader_pkg.sv
// Shared constants, FSM encoding and the CRC-8 bit step for the key loader.
package key_loader_pkg;

  localparam int          KEY_W    = 52;
  localparam int          CRC_W    = 8;
  localparam logic [7:0]  CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    DONE,
    FAIL
  } state_t;

  // One MSB-first step of CRC-8 (no reflection, no final xor).
  function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_loader_crc8.sv
// Bit-serial CRC-8 accumulator with synchronous clear and enable.
module key_crc8
  import key_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n)   crc <= 8'h00;
    else if (clr) crc <= 8'h00;
    else if (en)  crc <= crc8_bit(crc, din);
  end

endmodule

// File: rtl/key_loader.sv
// Serial key-store loader: shifts key + CRC-8, verifies, retries, then drives
// the locking key onto the keyed core.
module key_loader #(
  parameter int KEY_W   = key_loader_pkg::KEY_W,
  parameter int CRC_W   = key_loader_pkg::CRC_W,
  parameter int MAX_TRY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             otp_valid,
  input  logic             otp_bit,
  output logic             otp_ready,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy
);
  import key_loader_pkg::*;

  localparam int CNT_W = $clog2(KEY_W + CRC_W + 1);
  localparam int TRY_W = $clog2(MAX_TRY + 1);
  localparam logic [CNT_W-1:0] KEY_END  = CNT_W'(KEY_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W + CRC_W - 1);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRY);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [TRY_W-1:0]   try_cnt;
  logic [KEY_W-1:0]   stage;
  logic [CRC_W-1:0]   recv;
  logic [7:0]         crc_val;

  logic idle_like, load_go, xfer, in_key, last_xfer, crc_ok, retry;

  assign idle_like = (state == IDLE) || (state == DONE) || (state == FAIL);
  assign load_go   = idle_like && start;
  assign xfer      = (state == SHIFT) && otp_valid;
  assign in_key    = cnt < KEY_END;
  assign last_xfer = xfer && (cnt == LAST_BIT);
  assign crc_ok    = recv == crc_val[CRC_W-1:0];
  assign retry     = (state == CHECK) && !crc_ok && (try_cnt < TRY_MAX);

  key_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_go || retry),
    .en    (xfer && in_key),
    .din   (otp_bit),
    .crc   (crc_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, FAIL: if (start) state_nxt = SHIFT;
      SHIFT:            if (last_xfer) state_nxt = CHECK;
      CHECK: begin
        if (crc_ok)     state_nxt = DONE;
        else if (retry) state_nxt = SHIFT;
        else            state_nxt = FAIL;
      end
      default:          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    otp_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      SHIFT: begin otp_ready = 1'b1; busy = 1'b1; end
      CHECK: busy = 1'b1;
      default: ;
    endcase
  end

  // Staging stays private; keyinput only ever sees a CRC-verified key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      try_cnt   <= '0;
      stage     <= '0;
      recv      <= '0;
      keyinput  <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
    end else if (load_go) begin
      cnt       <= '0;
      try_cnt   <= TRY_W'(1);
      stage     <= '0;
      recv      <= '0;
      keyinput  <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
    end else if (xfer) begin
      cnt <= cnt + 1'b1;
      if (in_key) stage <= {stage[KEY_W-2:0], otp_bit};
      else        recv  <= {recv[CRC_W-2:0], otp_bit};
    end else if (state == CHECK) begin
      if (crc_ok) begin
        keyinput  <= stage;
        key_valid <= 1'b1;
      end else if (retry) begin
        try_cnt <= try_cnt + 1'b1;
        cnt     <= '0;
        stage   <= '0;
        recv    <= '0;
      end else begin
        key_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: reset, latency, paced input, retries, error, reset abort.
module tb_key_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, otp_valid, otp_bit;
  logic        otp_ready, key_valid, key_err, busy;
  logic [51:0] keyinput;

  int n_tests = 0;
  int n_fail  = 0;

  key_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .otp_valid (otp_valid),
    .otp_bit   (otp_bit),
    .otp_ready (otp_ready),
    .keyinput  (keyinput),
    .key_valid (key_valid),
    .key_err   (key_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // CRC-8 poly 0x07, init 0, key MSB first
  function automatic logic [7:0] crc_of(input logic [51:0] k);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 51; i >= 0; i--) begin
      if (c[7] ^ k[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Sends n bits of {key,crc} MSB first; optional idle cycle before each bit,
  // optional stray start pulse at bit index start_at.
  task automatic send_bits(input logic [51:0] k, input logic [7:0] c, input int n,
                           input bit gap, input int start_at);
    logic [59:0] f;
    f = {k, c};
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        otp_valid = 1'b0;
        tick();
      end
      otp_valid = 1'b1;
      otp_bit   = f[59-i];
      start     = (i == start_at);
      tick();
      start     = 1'b0;
      if (i < 59 && keyinput !== 52'h0) chk("keyinput_hidden", keyinput, 64'h0);
    end
    otp_valid = 1'b0;
  endtask

  task automatic in_check(input string tag);
    chk({tag, "_check_busy"}, {otp_ready, busy, key_valid}, 3'b010);
    chk({tag, "_check_key0"}, keyinput, 64'h0);
  endtask

  logic [51:0] k_a, k_b;

  initial begin
    rst_n = 1'b0; start = 1'b0; otp_valid = 1'b0; otp_bit = 1'b0;
    k_a = 52'hA_5A5A_5A5A_5A5A;
    k_b = 52'h3_C0FF_EE12_3456;

    // reset held, then idle with no start
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++)
      chk("idle_outputs", {keyinput, key_valid, key_err, busy, otp_ready}, 64'h0);

    // stray otp_valid in IDLE consumes nothing
    otp_valid = 1'b1; otp_bit = 1'b1;
    repeat (5) tick();
    otp_valid = 1'b0;

    // all-zero key, CRC 0x00, valid held high: key_valid on cycle 62
    pulse_start();
    chk("zero_busy_after_start", {otp_ready, busy}, 2'b11);
    send_bits(52'h0, 8'h00, 60, 1'b0, -1);
    chk("zero_not_valid_cycle61", key_valid, 1'b0);
    in_check("zero");
    tick();
    chk("zero_valid_cycle62", {key_valid, key_err, busy}, 3'b100);
    chk("zero_keyinput", keyinput, 64'h0);

    // paced input, stray start mid-load ignored
    pulse_start();
    send_bits(k_a, crc_of(k_a), 60, 1'b1, 20);
    in_check("a5");
    tick();
    chk("a5_valid", {key_valid, key_err, busy}, 3'b100);
    chk("a5_keyinput", keyinput, {12'h0, k_a});

    // otp_valid in DONE ignored; start in DONE clears on the same edge
    otp_valid = 1'b1;
    repeat (3) tick();
    otp_valid = 1'b0;
    chk("done_hold_key", keyinput, {12'h0, k_a});
    pulse_start();
    chk("restart_clears", {keyinput, key_valid, key_err, busy}, 64'h1);

    // two bad CRCs then good
    send_bits(k_b, crc_of(k_b) ^ 8'h01, 60, 1'b0, -1);
    in_check("retry1");
    tick();
    chk("retry1_busy", {busy, key_valid, key_err, otp_ready}, 4'b1001);
    send_bits(k_b, crc_of(k_b) ^ 8'h01, 60, 1'b0, -1);
    tick();
    chk("retry2_busy", {busy, key_valid, key_err, otp_ready}, 4'b1001);
    send_bits(k_b, crc_of(k_b), 60, 1'b0, -1);
    in_check("retry3");
    tick();
    chk("retry3_valid", {key_valid, key_err, busy}, 3'b100);
    chk("retry3_keyinput", keyinput, {12'h0, k_b});

    // three bad CRCs -> error
    pulse_start();
    for (int t = 0; t < 3; t++) begin
      send_bits(k_a, crc_of(k_a) ^ 8'h80, 60, 1'b0, -1);
      tick();
    end
    chk("err_flags", {key_err, key_valid, busy, otp_ready}, 4'b1000);
    chk("err_keyinput", keyinput, 64'h0);
    otp_valid = 1'b1;
    repeat (3) tick();
    otp_valid = 1'b0;
    chk("err_hold", {key_err, busy}, 2'b10);
    pulse_start();
    chk("err_cleared", {key_err, key_valid, busy}, 3'b001);
    send_bits(k_a, crc_of(k_a), 60, 1'b0, -1);
    tick();
    chk("err_reload_valid", {key_valid, key_err}, 2'b10);
    chk("err_reload_key", keyinput, {12'h0, k_a});

    // reset mid-SHIFT abandons the load
    pulse_start();
    send_bits(k_b, crc_of(k_b), 30, 1'b0, -1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_outputs", {keyinput, key_valid, key_err, busy, otp_ready}, 64'h0);
    tick();
    chk("rst_mid_idle", {keyinput, busy}, 64'h0);
    pulse_start();
    send_bits(k_b, crc_of(k_b), 60, 1'b0, -1);
    in_check("rst_reload");
    tick();
    chk("rst_reload_valid", {key_valid, key_err, busy}, 3'b100);
    chk("rst_reload_key", keyinput, {12'h0, k_b});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
